// File: rtl/vread_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vread_fill_pkg
// Purpose  : Shared versat definitions for the vread_fill block: FSM state
//            encoding, external/internal address widths and the beat-length
//            field width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vread_fill_pkg;

  localparam int IO_ADDR_W  = 32;
  localparam int MEM_ADDR_W = 10;
  localparam int LEN_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vread_fill_addr_calc.sv
`default_nettype none
// ============================================================================
// Module   : fill_addr_calc
// Purpose  : Internal memory write address for the current beat:
//            base + offset, wrapping modulo 2^ADDR_W. In ping-pong mode the
//            base MSB is replaced by the active ping-pong half.
// Ports    : i_int_addr   - latched internal base address
//            i_pp_en      - latched ping-pong enable
//            i_pp_state   - current ping-pong half
//            i_offset     - beat count (offset from base)
//            o_addr       - resulting memory address
// Revision : 1.0 - initial release
// ============================================================================
module fill_addr_calc #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] i_int_addr,
  input  logic              i_pp_en,
  input  logic              i_pp_state,
  input  logic [LEN_W-1:0]  i_offset,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0]       w_base;
  logic [ADDR_W+LEN_W-1:0] w_sum;

  always_comb begin
    w_base = i_int_addr;
    if (i_pp_en) begin
      w_base[ADDR_W-1] = i_pp_state;
    end
  end

  // Sum computed wide enough for either operand, then truncated so the
  // address wraps around the top of the internal memory.
  assign w_sum  = {{LEN_W{1'b0}}, w_base} + {{ADDR_W{1'b0}}, i_offset};
  assign o_addr = w_sum[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/vread_fill.sv
`default_nettype none
// ============================================================================
// Module   : vread_fill
// Purpose  : Reads a burst of (length+1) beats from an external data bus and
//            writes them into internal memory at consecutive addresses, with
//            optional ping-pong double buffering and protocol error flagging.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            run                 - start pulse (accepted in IDLE/DONE)
//            done, err           - idle/complete flag, sticky protocol error
//            databus_*           - external read bus (valid/ready/addr/len/
//                                  rdata/last)
//            mem_write/addr/wdata- internal memory write port
//            ext_addr, int_addr, length, ping_pong - configuration, sampled
//                                  on an accepted run
//            pp_state            - ping-pong half currently being written
// Revision : 1.0 - initial release
// ============================================================================
module vread_fill #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = vread_fill_pkg::MEM_ADDR_W,
  parameter int IO_ADDR_W = vread_fill_pkg::IO_ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             run,
  output logic                             done,
  output logic                             err,
  output logic                             databus_valid,
  input  logic                             databus_ready,
  output logic [IO_ADDR_W-1:0]             databus_addr,
  input  logic [DATA_W-1:0]                databus_rdata,
  output logic [vread_fill_pkg::LEN_W-1:0] databus_len,
  input  logic                             databus_last,
  output logic                             mem_write,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic [IO_ADDR_W-1:0]             ext_addr,
  input  logic [ADDR_W-1:0]                int_addr,
  input  logic [vread_fill_pkg::LEN_W-1:0] length,
  input  logic                             ping_pong,
  output logic                             pp_state
);

  import vread_fill_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_run_acc;
  logic                 w_beat;
  logic                 w_err_set;

  logic [IO_ADDR_W-1:0] r_ext_addr;
  logic [ADDR_W-1:0]    r_int_addr;
  logic [LEN_W-1:0]     r_len;
  logic                 r_pp_en;
  logic                 r_pp_state;
  logic [LEN_W-1:0]     r_beat_count;
  logic                 r_err;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and per-cycle strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_run_acc   = 1'b0;
    w_beat      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (run) begin
          w_run_acc   = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        // databus_valid is high throughout BURST, so ready alone accepts.
        if (databus_ready) begin
          w_beat = 1'b1;
          if (databus_last) begin
            w_state_nxt = ST_DONE;
            w_err_set   = (r_beat_count < r_len);
          end else if (r_beat_count == r_len) begin
            // Final expected beat without a last marker: stop and flag.
            w_state_nxt = ST_DONE;
            w_err_set   = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Configuration, beat counter, ping-pong and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext_addr   <= '0;
      r_int_addr   <= '0;
      r_len        <= '0;
      r_pp_en      <= 1'b0;
      r_pp_state   <= 1'b0;
      r_beat_count <= '0;
      r_err        <= 1'b0;
    end else if (w_run_acc) begin
      r_ext_addr   <= ext_addr;
      r_int_addr   <= int_addr;
      r_len        <= length;
      r_pp_en      <= ping_pong;
      r_pp_state   <= ping_pong ? ~r_pp_state : 1'b0;
      r_beat_count <= '0;
      r_err        <= 1'b0;
    end else if (w_beat) begin
      r_beat_count <= r_beat_count + 1'b1;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  fill_addr_calc #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_calc (
    .i_int_addr (r_int_addr),
    .i_pp_en    (r_pp_en),
    .i_pp_state (r_pp_state),
    .i_offset   (r_beat_count),
    .o_addr     (mem_addr)
  );

  assign done          = (r_state != ST_BURST);
  assign databus_valid = (r_state == ST_BURST);
  assign err           = r_err;
  assign databus_addr  = r_ext_addr;
  assign databus_len   = r_len;
  assign pp_state      = r_pp_state;
  assign mem_write     = w_beat;
  assign mem_wdata     = databus_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vread_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_vread_fill
// Purpose  : Self-checking bench for vread_fill: directed scenarios plus
//            randomized bursts checked against a behavioural transfer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vread_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        done, err;
  logic        databus_valid;
  logic        databus_ready;
  logic [31:0] databus_addr;
  logic [31:0] databus_rdata;
  logic [7:0]  databus_len;
  logic        databus_last;
  logic        mem_write;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] ext_addr;
  logic [9:0]  int_addr;
  logic [7:0]  length;
  logic        ping_pong;
  logic        pp_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_pp = 1'b0;

  always #5 clk = ~clk;

  vread_fill #(
    .DATA_W    (32),
    .ADDR_W    (10),
    .IO_ADDR_W (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .done          (done),
    .err           (err),
    .databus_valid (databus_valid),
    .databus_ready (databus_ready),
    .databus_addr  (databus_addr),
    .databus_rdata (databus_rdata),
    .databus_len   (databus_len),
    .databus_last  (databus_last),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .ext_addr      (ext_addr),
    .int_addr      (int_addr),
    .length        (length),
    .ping_pong     (ping_pong),
    .pp_state      (pp_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. last_beat is the 1-based beat carrying the last
  // marker (0 = never). rmode: 0 ready always, 1 ready alternating, 2 random.
  // poke issues a run pulse with scrambled config in the middle of the burst.
  task automatic xfer(input logic [31:0] ext, input logic [9:0] ia, input logic [7:0] len,
                      input bit ppen, input int last_beat, input int rmode, input bit poke);
    int n_exp;
    int k;
    int cyc;
    int base;
    bit exp_err;
    bit poked;
    bit rdy;

    // Reference model of the whole transfer
    model_pp = ppen ? ~model_pp : 1'b0;
    base     = ppen ? ((int'(ia) & 'h1FF) | (int'(model_pp) << 9)) : int'(ia);
    n_exp    = int'(len) + 1;
    if (last_beat > 0 && last_beat < n_exp) n_exp = last_beat;
    exp_err  = (last_beat != int'(len) + 1);

    ext_addr = ext; int_addr = ia; length = len; ping_pong = ppen;
    databus_ready = 1'b0; databus_last = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    ext_addr = $urandom; int_addr = 10'($urandom); length = 8'($urandom); ping_pong = 1'($urandom);
    check("start_done", done, 0);
    check("start_valid", databus_valid, 1);
    check("start_err", err, 0);
    check("start_addr", databus_addr, ext);
    check("start_len", databus_len, len);
    check("start_pp", pp_state, model_pp);

    k = 0; cyc = 0; poked = 0;
    while (k < n_exp && cyc < 300) begin
      if (poke && !poked && k == 1) begin
        poked = 1;
        databus_ready = 1'b0; databus_last = 1'b0;
        run = 1'b1;
        #1;
        check("poke_nowrite", mem_write, 0);
        @(posedge clk); #1;
        run = 1'b0;
        check("poke_addr", databus_addr, ext);
        check("poke_len", databus_len, len);
        check("poke_pp", pp_state, model_pp);
        check("poke_valid", databus_valid, 1);
        cyc++;
        continue;
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      databus_ready = rdy;
      databus_rdata = $urandom;
      databus_last  = rdy && (k + 1 == last_beat);
      #1;
      if (rdy) begin
        check("beat_write", mem_write, 1);
        check("beat_addr", mem_addr, 64'((base + k) % 1024));
        check("beat_data", mem_wdata, databus_rdata);
        k++;
      end else begin
        check("idle_cycle_nowrite", mem_write, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    databus_ready = 1'b0; databus_last = 1'b0;
    check("beat_count", k, n_exp);
    check("end_done", done, 1);
    check("end_valid", databus_valid, 0);
    check("end_err", err, exp_err);
    databus_ready = 1'b1; databus_last = 1'b1; databus_rdata = $urandom;
    #1;
    check("done_nowrite", mem_write, 0);
    databus_ready = 1'b0; databus_last = 1'b0;
    @(posedge clk); #1;
    check("done_hold", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  r_ia;
    logic [31:0] r_ext;
    logic [7:0]  r_len;
    int          r_last;

    rst = 1'b1; run = 1'b0;
    databus_ready = 1'b0; databus_rdata = '0; databus_last = 1'b0;
    ext_addr = '0; int_addr = '0; length = '0; ping_pong = 1'b0;

    // Reset state, with bus activity that must be ignored
    repeat (2) @(posedge clk);
    #1;
    databus_ready = 1'b1; databus_last = 1'b1;
    #1;
    check("rst_done", done, 1);
    check("rst_err", err, 0);
    check("rst_valid", databus_valid, 0);
    check("rst_write", mem_write, 0);
    check("rst_pp", pp_state, 0);
    check("rst_addr", databus_addr, 0);
    check("rst_len", databus_len, 0);
    databus_ready = 1'b0; databus_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_done", done, 1);

    // Basic burst, ready every cycle
    xfer(32'h1000, 10'h010, 8'd3, 1'b0, 4, 0, 1'b0);
    // Same config, ready alternating
    xfer(32'h1000, 10'h010, 8'd3, 1'b0, 4, 1, 1'b0);
    // Address wrap at top of memory
    xfer(32'h2000, 10'h3FE, 8'd3, 1'b0, 4, 0, 1'b0);
    // Ping-pong: bases 0x200 then 0x000
    xfer(32'h3000, 10'h000, 8'd2, 1'b1, 3, 0, 1'b0);
    xfer(32'h3000, 10'h000, 8'd2, 1'b1, 3, 0, 1'b0);
    // Early last -> error, with an ignored mid-burst run
    xfer(32'h4000, 10'h020, 8'd3, 1'b0, 2, 0, 1'b1);
    // Next run clears err
    xfer(32'h5000, 10'h030, 8'd1, 1'b0, 2, 0, 1'b0);
    // Missing last -> error
    xfer(32'h6000, 10'h040, 8'd2, 1'b0, 0, 0, 1'b0);
    // Single-beat burst
    xfer(32'h7000, 10'h050, 8'd0, 1'b0, 1, 1, 1'b0);

    // Reset mid-burst after 2 of 4 beats
    ext_addr = 32'h8000; int_addr = 10'h060; length = 8'd3; ping_pong = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      databus_ready = 1'b1; databus_rdata = $urandom;
      @(posedge clk); #1;
    end
    databus_ready = 1'b1; databus_rdata = $urandom;
    rst = 1'b1;
    #1;
    check("midrst_done", done, 1);
    check("midrst_valid", databus_valid, 0);
    check("midrst_write", mem_write, 0);
    check("midrst_pp", pp_state, 0);
    check("midrst_addr", databus_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_pp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      databus_rdata = $urandom;
      #1;
      check("postrst_nowrite", mem_write, 0);
      @(posedge clk); #1;
    end
    databus_ready = 1'b0;

    // Randomized bursts against the model
    for (int t = 0; t < 24; t++) begin
      r_ia  = 10'($urandom);
      r_ext = $urandom;
      r_len = 8'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0, 1:    r_last = int'(r_len) + 1;
        2:       r_last = $urandom_range(1, int'(r_len) + 1);
        default: r_last = 0;
      endcase
      xfer(r_ext, r_ia, r_len, 1'($urandom_range(0, 1)), r_last, 2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
